count_stream_checker: RTL

- Receiving end of the counter stimulus stream: accepts incrementing count values over a valid/ready interface, buffers them in a small FIFO and checks them in order.
- Flags sequence errors, records hits on two target values, and signals done after a programmed number of good items.
- Sits beside the stimulus generator in simulation tops as the self-checking consumer. Fully synthesizable.

---
 rtl/count_stream_checker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/count_stream_checker.sv
// Consumer end of the counter stream: buffers incoming counts in a small FIFO and checks them
// in order against an incrementing expected value, flagging the first mismatch.
module count_stream_checker #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      TOTAL = 100,
  parameter logic [WIDTH-1:0] START = '0,
  parameter logic [WIDTH-1:0] HIT_A = WIDTH'(30),
  parameter logic [WIDTH-1:0] HIT_B = WIDTH'(50),
  parameter int unsigned      DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             drain_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_got,
  output logic [15:0]      checked,
  output logic             hit_a,
  output logic             hit_b
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [15:0]      checked_q, checked_d, checked_inc;
  logic             hit_a_q, hit_a_d, hit_b_q, hit_b_d;
  logic [WIDTH-1:0] err_expected_q, err_expected_d, err_got_q, err_got_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head;
  logic             full, empty, push, pop, restart;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready    = (state_q == StRun) && !full;
  assign push        = in_valid && in_ready;
  assign pop         = (state_q == StRun) && !empty && drain_en;
  assign head        = mem[rd_ptr_q];
  assign checked_inc = checked_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    expected_d     = expected_q;
    checked_d      = checked_q;
    hit_a_d        = hit_a_q;
    hit_b_d        = hit_b_q;
    err_expected_d = err_expected_q;
    err_got_d      = err_got_q;
    restart        = 1'b0;

    unique case (state_q)
      StIdle: restart = start;
      StRun: begin
        if (pop) begin
          if (head == expected_q) begin
            checked_d  = checked_inc;
            expected_d = expected_q + WIDTH'(1);
            if (head == HIT_A) hit_a_d = 1'b1;
            if (head == HIT_B) hit_b_d = 1'b1;
            if (checked_inc == 16'(TOTAL)) state_d = StDone;
          end else begin
            state_d        = StError;
            err_expected_d = expected_q;
            err_got_d      = head;
          end
        end
      end
      StDone, StError: restart = start;
      default: state_d = StIdle;
    endcase

    // Re-arm: leftover FIFO contents from a finished run are discarded here.
    if (restart) begin
      state_d        = StRun;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      expected_d     = START;
      checked_d      = '0;
      hit_a_d        = 1'b0;
      hit_b_d        = 1'b0;
      err_expected_d = '0;
      err_got_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      expected_q     <= START;
      checked_q      <= '0;
      hit_a_q        <= 1'b0;
      hit_b_q        <= 1'b0;
      err_expected_q <= '0;
      err_got_q      <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      expected_q     <= expected_d;
      checked_q      <= checked_d;
      hit_a_q        <= hit_a_d;
      hit_b_q        <= hit_b_d;
      err_expected_q <= err_expected_d;
      err_got_q      <= err_got_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StError);
  assign err_expected = err_expected_q;
  assign err_got      = err_got_q;
  assign checked      = checked_q;
  assign hit_a        = hit_a_q;
  assign hit_b        = hit_b_q;

endmodule
